// File: rtl/makestuff_tlp_regfile_pkg.sv
// ---------------------------------------------------------------------------
// makestuff_tlp_regfile_pkg
//   Shared types for the host register-pipe register file: the channel
//   number carried by the xcvr, the read-side state encoding and the layout
//   of the word returned by the status channel.
// ---------------------------------------------------------------------------
package makestuff_tlp_regfile_pkg;

  // Channel number as presented by makestuff_tlp_xcvr.
  typedef logic [6:0] Channel;

  // Channel as held by the register file while a read is in flight.
  typedef Channel RegChan;

  // Host read sequencing.
  typedef enum logic [1:0] {
    RD_IDLE,
    RD_FETCH,
    RD_HOLD
  } RdState;

  // Word returned by a read of the status channel.
  typedef struct packed {
    logic [15:0] stallCount;
    logic [15:0] dropCount;
  } StatusWord;

endpackage

// File: rtl/makestuff_tlp_regfile_skid.sv
// ---------------------------------------------------------------------------
// makestuff_reg_skid
//   Two-entry valid/ready skid buffer. inReady depends only on the buffer
//   occupancy, so there is no combinational path from outReady back to
//   inReady. One entry sustains one word per cycle when the consumer is
//   always ready; the second entry absorbs a word while the consumer stalls.
//
// Ports
//   clk       in   1       clock
//   rstN      in   1       asynchronous active-low reset; empties the buffer
//   inData    in   WIDTH   producer data
//   inValid   in   1       producer valid
//   inReady   out  1       buffer has a free entry
//   outData   out  WIDTH   oldest buffered word
//   outValid  out  1       buffer not empty
//   outReady  in   1       consumer accepts outData
//   full      out  1       both entries occupied
// ---------------------------------------------------------------------------
module makestuff_reg_skid #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic [WIDTH-1:0] inData,
  input  logic             inValid,
  output logic             inReady,
  output logic [WIDTH-1:0] outData,
  output logic             outValid,
  input  logic             outReady,
  output logic             full
);

  logic [WIDTH-1:0] slot [2];
  logic             wrPtr;
  logic             rdPtr;
  logic [1:0]       count;
  logic             push;
  logic             pop;

  assign inReady  = (count != 2'd2);
  assign outValid = (count != 2'd0);
  assign full     = (count == 2'd2);
  assign outData  = slot[rdPtr];
  assign push     = inValid && inReady;
  assign pop      = outValid && outReady;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      slot[0] <= '0;
      slot[1] <= '0;
      wrPtr   <= 1'b0;
      rdPtr   <= 1'b0;
      count   <= 2'd0;
    end else begin
      if (push) begin
        slot[wrPtr] <= inData;
        wrPtr       <= ~wrPtr;
      end
      if (pop) begin
        rdPtr <= ~rdPtr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/makestuff_tlp_regfile.sv
// ---------------------------------------------------------------------------
// makestuff_tlp_regfile
//   Channel-addressed register file sitting directly downstream of
//   makestuff_tlp_xcvr. Host writes and reads are terminated in:
//     - NUM_REGS plain read/write registers (channels 0..NUM_REGS-1),
//     - a stream channel bridged to the user usrWr*/usrRd* pipes,
//     - a read-only status channel {stallCount, dropCount}.
//   Any other channel is absorbed (writes dropped and counted, reads return
//   BAD_READ) so a stray host access can never wedge the xcvr.
//
// Ports
//   pcieClk_in      in   1            core clock shared with the xcvr
//   pcieRstN_in     in   1            asynchronous active-low reset
//   cpuChan_in      in   7            channel; stable while an access is pending
//   cpuWrData_in    in   32           host write data
//   cpuWrValid_in   in   1            host write valid
//   cpuWrReady_out  out  1            host write accepted (with cpuWrValid_in)
//   cpuRdData_out   out  32           host read data
//   cpuRdValid_out  out  1            host read data valid
//   cpuRdReady_in   in   1            host read request / read data accept
//   regs_out        out  32*NUM_REGS  register n at [32n+31:32n]
//   usrWrData_out   out  32           stream write data to user logic
//   usrWrValid_out  out  1            stream write valid
//   usrWrReady_in   in   1            user accepts stream write
//   usrRdData_in    in   32           user data for stream reads
//   usrRdValid_in   in   1            user read data valid
//   usrRdReady_out  out  1            pops the user read pipe
// ---------------------------------------------------------------------------
module makestuff_tlp_regfile
  import makestuff_tlp_regfile_pkg::*;
#(
  parameter int          NUM_REGS    = 4,
  parameter logic [6:0]  STREAM_CHAN = 7'h7E,
  parameter logic [6:0]  STATUS_CHAN = 7'h7F,
  parameter logic [31:0] BAD_READ    = 32'hDEADBEEF
) (
  input  logic                    pcieClk_in,
  input  logic                    pcieRstN_in,
  input  logic [6:0]              cpuChan_in,
  input  logic [31:0]             cpuWrData_in,
  input  logic                    cpuWrValid_in,
  output logic                    cpuWrReady_out,
  output logic [31:0]             cpuRdData_out,
  output logic                    cpuRdValid_out,
  input  logic                    cpuRdReady_in,
  output logic [32*NUM_REGS-1:0]  regs_out,
  output logic [31:0]             usrWrData_out,
  output logic                    usrWrValid_out,
  input  logic                    usrWrReady_in,
  input  logic [31:0]             usrRdData_in,
  input  logic                    usrRdValid_in,
  output logic                    usrRdReady_out
);

  localparam int         IDX_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [7:0] NUM_REGS_C = 8'(NUM_REGS);

  function automatic logic chanIsReg(input Channel ch);
    return ({1'b0, ch} < NUM_REGS_C);
  endfunction

  function automatic logic [15:0] satInc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [31:0]      regFile [NUM_REGS];
  StatusWord        status;

  // Write-side decode of the live channel.
  logic             wrIsReg;
  logic             wrIsStream;
  logic             wrIsStatus;
  logic             wrIsUnmapped;
  logic [IDX_W-1:0] wrIdx;
  logic             wrFire;

  logic             skidInReady;
  logic             skidFull;

  // Read-side state.
  RdState           rdState;
  RegChan           rdChan_p0;
  logic             rdIsStream;
  logic [IDX_W-1:0] rdIdx;
  logic [31:0]      fetchData;

  assign wrIsReg      = chanIsReg(cpuChan_in);
  assign wrIsStream   = (cpuChan_in == STREAM_CHAN);
  assign wrIsStatus   = (cpuChan_in == STATUS_CHAN);
  assign wrIsUnmapped = !wrIsReg && !wrIsStream && !wrIsStatus;
  assign wrIdx        = cpuChan_in[IDX_W-1:0];

  // Held low throughout reset so nothing is accepted while the skid and
  // counters are being cleared.
  assign cpuWrReady_out = pcieRstN_in && (wrIsStream ? skidInReady : 1'b1);
  assign wrFire         = cpuWrValid_in && cpuWrReady_out;

  // Stream write path
  makestuff_reg_skid #(
    .WIDTH(32)
  ) uSkid (
    .clk      (pcieClk_in),
    .rstN     (pcieRstN_in),
    .inData   (cpuWrData_in),
    .inValid  (cpuWrValid_in && wrIsStream),
    .inReady  (skidInReady),
    .outData  (usrWrData_out),
    .outValid (usrWrValid_out),
    .outReady (usrWrReady_in),
    .full     (skidFull)
  );

  // Register writes
  always_ff @(posedge pcieClk_in or negedge pcieRstN_in) begin
    if (!pcieRstN_in) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regFile[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wrFire && wrIsReg && (wrIdx == IDX_W'(i))) begin
          regFile[i] <= cpuWrData_in;
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : gRegsOut
    assign regs_out[32*g +: 32] = regFile[g];
  end

  // Status counters; a status-channel write takes priority over a stall
  // increment in the same cycle.
  always_ff @(posedge pcieClk_in or negedge pcieRstN_in) begin
    if (!pcieRstN_in) begin
      status <= '0;
    end else if (wrFire && wrIsStatus) begin
      status <= '0;
    end else begin
      if (skidFull && !usrWrReady_in) begin
        status.stallCount <= satInc16(status.stallCount);
      end
      if (wrFire && wrIsUnmapped) begin
        status.dropCount <= satInc16(status.dropCount);
      end
    end
  end

  // Read fetch decode on the latched channel
  assign rdIsStream = (rdChan_p0 == STREAM_CHAN);
  assign rdIdx      = rdChan_p0[IDX_W-1:0];

  // Reads sample register contents before any same-cycle write lands.
  always_comb begin
    fetchData = BAD_READ;
    if (chanIsReg(rdChan_p0)) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (rdIdx == IDX_W'(i)) begin
          fetchData = regFile[i];
        end
      end
    end else if (rdChan_p0 == STATUS_CHAN) begin
      fetchData = status;
    end
  end

  // Only pops while a stream fetch is outstanding; reset forces RD_IDLE
  // asynchronously, so no pop can occur once reset asserts.
  assign usrRdReady_out = (rdState == RD_FETCH) && rdIsStream && usrRdValid_in;

  // Read FSM: IDLE -> FETCH -> HOLD -> IDLE
  always_ff @(posedge pcieClk_in or negedge pcieRstN_in) begin
    if (!pcieRstN_in) begin
      rdState        <= RD_IDLE;
      rdChan_p0      <= '0;
      cpuRdData_out  <= '0;
      cpuRdValid_out <= 1'b0;
    end else begin
      case (rdState)
        RD_IDLE: begin
          if (cpuRdReady_in) begin
            rdChan_p0 <= cpuChan_in;
            rdState   <= RD_FETCH;
          end
        end
        RD_FETCH: begin
          if (rdIsStream) begin
            if (usrRdValid_in) begin
              cpuRdData_out  <= usrRdData_in;
              cpuRdValid_out <= 1'b1;
              rdState        <= RD_HOLD;
            end
          end else begin
            cpuRdData_out  <= fetchData;
            cpuRdValid_out <= 1'b1;
            rdState        <= RD_HOLD;
          end
        end
        RD_HOLD: begin
          if (cpuRdReady_in) begin
            cpuRdValid_out <= 1'b0;
            rdState        <= RD_IDLE;
          end
        end
        default: begin
          cpuRdValid_out <= 1'b0;
          rdState        <= RD_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_makestuff_tlp_regfile.sv
module tb_makestuff_tlp_regfile;

  localparam int          NR     = 4;
  localparam logic [6:0]  STREAM = 7'h7E;
  localparam logic [6:0]  STATUS = 7'h7F;
  localparam logic [31:0] BAD    = 32'hDEADBEEF;

  logic              clk = 1'b0;
  logic              rstN = 1'b0;
  logic [6:0]        chan = '0;
  logic [31:0]       wrData = '0;
  logic              wrValid = 1'b0;
  logic              wrReady;
  logic [31:0]       rdData;
  logic              rdValid;
  logic              rdReady = 1'b0;
  logic [32*NR-1:0]  regsOut;
  logic [31:0]       usrWrData;
  logic              usrWrValid;
  logic              usrWrReady = 1'b0;
  logic [31:0]       usrRdData = '0;
  logic              usrRdValid = 1'b0;
  logic              usrRdReady;

  makestuff_tlp_regfile #(
    .NUM_REGS(NR), .STREAM_CHAN(STREAM), .STATUS_CHAN(STATUS), .BAD_READ(BAD)
  ) dut (
    .pcieClk_in(clk), .pcieRstN_in(rstN), .cpuChan_in(chan),
    .cpuWrData_in(wrData), .cpuWrValid_in(wrValid), .cpuWrReady_out(wrReady),
    .cpuRdData_out(rdData), .cpuRdValid_out(rdValid), .cpuRdReady_in(rdReady),
    .regs_out(regsOut), .usrWrData_out(usrWrData), .usrWrValid_out(usrWrValid),
    .usrWrReady_in(usrWrReady), .usrRdData_in(usrRdData), .usrRdValid_in(usrRdValid),
    .usrRdReady_out(usrRdReady)
  );

  always #5 clk = ~clk;

  int nVec = 0;
  int nMis = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nMis++;
      $display("FAIL %s: got %0h, wanted %0h", nm, act, exp);
    end
  endtask

  task automatic failNow(input string nm);
    nVec++;
    nMis++;
    $display("FAIL %s: event did not occur as required", nm);
  endtask

  // ---------------- reference model ----------------
  logic [31:0] mRegs [NR];
  logic [15:0] mDrop, mStall;
  int          occ;
  logic [31:0] expUsr[$];
  logic [31:0] expRd[$];
  int          rdPhase;      // 0 waiting for request, 1 fetch cycle(s), 2 data presented
  logic [6:0]  rdChan;
  logic        mWrAcc, mPop, mUsrPop;
  int          popsSeen = 0;
  bit          randEn = 0;

  function automatic logic [15:0] sat16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [31:0] hostReadValue(input logic [6:0] c);
    if (c < 7'(NR)) return mRegs[c[1:0]];
    if (c == STATUS) return {mStall, mDrop};
    return BAD;
  endfunction

  always @(negedge clk) begin
    if (!rstN) begin
      for (int i = 0; i < NR; i++) mRegs[i] = '0;
      mDrop = '0; mStall = '0; occ = 0; rdPhase = 0; rdChan = '0;
      expUsr.delete(); expRd.delete();
    end else begin
      for (int i = 0; i < NR; i++)
        check($sformatf("reg%0d", i), regsOut[32*i +: 32], mRegs[i]);
      check("cpuRdValid", 32'(rdValid), 32'(rdPhase == 2));
      check("usrWrValid", 32'(usrWrValid), 32'(occ > 0));
      if (wrValid)
        check("cpuWrReady", 32'(wrReady), (chan == STREAM) ? 32'(occ < 2) : 32'd1);
      mWrAcc  = wrValid && (chan != STREAM || occ < 2);
      mPop    = (occ > 0) && usrWrReady;
      mUsrPop = (rdPhase == 1) && (rdChan == STREAM) && usrRdValid;
      check("usrRdReady", 32'(usrRdReady), 32'(mUsrPop));
      case (rdPhase)
        0: if (rdReady) begin rdChan = chan; rdPhase = 1; end
        1: begin
          if (rdChan == STREAM) begin
            if (mUsrPop) begin expRd.push_back(usrRdData); rdPhase = 2; end
          end else begin
            expRd.push_back(hostReadValue(rdChan));
            rdPhase = 2;
          end
        end
        default: if (rdReady) rdPhase = 0;
      endcase
      if (mWrAcc) begin
        if (chan < 7'(NR)) mRegs[chan[1:0]] = wrData;
        else if (chan == STREAM) expUsr.push_back(wrData);
        else if (chan == STATUS) begin mDrop = '0; mStall = '0; end
        else mDrop = sat16(mDrop);
      end
      if (!(mWrAcc && chan == STATUS) && occ == 2 && !usrWrReady) mStall = sat16(mStall);
      occ = occ + ((mWrAcc && chan == STREAM) ? 1 : 0) - (mPop ? 1 : 0);
    end
  end

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    if (rstN && usrWrValid && usrWrReady) begin
      if (expUsr.size() == 0) failNow("usrWrUnexpected");
      else check("usrWrData", usrWrData, expUsr.pop_front());
    end
  end

  always @(negedge clk) begin
    if (rstN && rdValid && rdReady) begin
      if (expRd.size() == 0) failNow("cpuRdUnexpected");
      else check("cpuRdData", rdData, expRd.pop_front());
    end
  end

  always @(negedge clk) begin
    if (rstN && usrRdReady && usrRdValid) popsSeen++;
  end

  // ---------------- drivers ----------------
  task automatic wrOp(input logic [6:0] c, input logic [31:0] d);
    int n = 0;
    chan = c; wrData = d; wrValid = 1'b1;
    do begin @(negedge clk); n++; end while (!wrReady && n < 200);
    if (!wrReady) failNow("wrTimeout");
    @(posedge clk); #1 wrValid = 1'b0;
  endtask

  task automatic rdOp(input logic [6:0] c, output logic [31:0] d, output int lat);
    lat = 0; chan = c; rdReady = 1'b1;
    @(negedge clk);
    while (!rdValid && lat < 200) begin @(negedge clk); lat++; end
    if (!rdValid) failNow("rdTimeout");
    d = rdData;
    @(posedge clk); #1 rdReady = 1'b0;
  endtask

  initial begin
    forever begin
      @(posedge clk); #1;
      if (randEn) begin
        usrWrReady = 1'($urandom_range(0, 1));
        usrRdValid = ($urandom_range(0, 3) == 0);
        usrRdData  = $urandom;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    int lat, p0, n;
    repeat (2) @(posedge clk);
    #1;
    check("rstRegs", 32'(regsOut != '0), 0);
    check("rstRdValid", 32'(rdValid), 0);
    check("rstWrReady", 32'(wrReady), 0);
    check("rstUsrWrValid", 32'(usrWrValid), 0);
    check("rstUsrRdReady", 32'(usrRdReady), 0);
    rstN = 1'b1;
    @(posedge clk); #1;

    // register write then read
    wrOp(7'd2, 32'h12345678);
    check("reg2Visible", regsOut[95:64], 32'h12345678);
    rdOp(7'd2, d, lat);
    check("reg2Read", d, 32'h12345678);
    check("reg2Latency", 32'(lat), 2);

    // unmapped channel
    wrOp(7'h40, 32'hA5A5A5A5);
    rdOp(7'h40, d, lat);
    check("unmappedRead", d, BAD);
    rdOp(STATUS, d, lat);
    check("statusDrop", d, 32'h00000001);

    // stream write with a stalled consumer
    usrWrReady = 1'b0;
    fork
      begin
        for (int i = 1; i <= 4; i++) wrOp(STREAM, 32'(i));
      end
      begin
        repeat (10) @(negedge clk);
        check("skidFullBlocks", 32'(wrReady), 0);
        @(posedge clk); #1 usrWrReady = 1'b1;
      end
    join
    repeat (5) @(posedge clk);
    #1;
    check("skidDrained", 32'(expUsr.size()), 0);
    rdOp(STATUS, d, lat);
    check("stallCounted", 32'(d[31:16] != 16'd0), 1);
    check("dropKept", 32'(d[15:0]), 1);
    wrOp(STATUS, $urandom);
    rdOp(STATUS, d, lat);
    check("statusCleared", d, 0);

    // stream read waiting on the user pipe
    usrRdValid = 1'b0;
    p0 = popsSeen;
    fork
      rdOp(STREAM, d, lat);
      begin
        repeat (12) @(posedge clk);
        #1 usrRdData = 32'hCAFEF00D; usrRdValid = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!usrRdReady && n < 50);
        @(posedge clk); #1 usrRdValid = 1'b0;
      end
    join
    check("streamRdData", d, 32'hCAFEF00D);
    check("streamRdOnePop", 32'(popsSeen - p0), 1);
    check("streamRdWaited", 32'(lat > 10), 1);

    // same-cycle write and fetch of reg 1
    chan = 7'd1; rdReady = 1'b1;
    @(posedge clk); #1 wrData = 32'h1; wrValid = 1'b1;
    @(posedge clk); #1 wrValid = 1'b0;
    @(negedge clk);
    check("rbwValid", 32'(rdValid), 1);
    check("rbwOld", rdData, 0);
    @(posedge clk); #1 rdReady = 1'b0;
    rdOp(7'd1, d, lat);
    check("rbwNew", d, 32'h1);

    // reset during HOLD with two words in the skid
    usrWrReady = 1'b0;
    wrOp(STREAM, 32'h11);
    wrOp(STREAM, 32'h22);
    chan = 7'd2; rdReady = 1'b1;
    @(posedge clk); #1 rdReady = 1'b0;
    repeat (3) @(posedge clk);
    #2 rstN = 1'b0;
    #1;
    check("midRstRdValid", 32'(rdValid), 0);
    check("midRstRdData", rdData, 0);
    check("midRstUsrWrValid", 32'(usrWrValid), 0);
    check("midRstUsrWrData", usrWrData, 0);
    check("midRstUsrRdReady", 32'(usrRdReady), 0);
    check("midRstWrReady", 32'(wrReady), 0);
    check("midRstRegs", 32'(regsOut != '0), 0);
    repeat (2) @(posedge clk);
    #1 rstN = 1'b1; usrWrReady = 1'b1; usrRdValid = 1'b1;
    p0 = popsSeen;
    repeat (10) @(posedge clk);
    #1;
    check("postRstNoPops", 32'(popsSeen - p0), 0);
    check("postRstNoWrites", 32'(usrWrValid), 0);
    usrRdValid = 1'b0;

    // randomized traffic
    randEn = 1;
    for (int k = 0; k < 150; k++) begin
      case ($urandom_range(0, 7))
        0: wrOp(7'($urandom_range(0, NR - 1)), $urandom);
        1: wrOp(7'($urandom_range(NR, 125)), $urandom);
        2: wrOp(STREAM, $urandom);
        3: if ($urandom_range(0, 3) == 0) wrOp(STATUS, $urandom);
           else rdOp(STATUS, d, lat);
        4: rdOp(7'($urandom_range(0, NR - 1)), d, lat);
        5: rdOp(7'($urandom_range(NR, 125)), d, lat);
        6: rdOp(STREAM, d, lat);
        default: wrOp(STREAM, $urandom);
      endcase
    end
    randEn = 0;
    @(posedge clk);
    #2 usrWrReady = 1'b1; usrRdValid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("drainUsr", 32'(expUsr.size()), 0);
    check("drainRd", 32'(expRd.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
